alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue_if.sv | 57 +++++
 rtl/alu_issue_queue.sv | 161 ++++++++++++++++
 tb/tb_alu_issue_queue.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_queue_if.sv
// alu_issue_queue_if -- bundle of every signal between the issue queue and
// its surroundings: the request channel, the operand/function bus to the
// ALU, the ALU result inputs and the result handshake channel.
//
// Signals:
//   req_valid, req_A[7:0], req_B[7:0], req_FunSel[3:0] : request in
//   req_ready                                          : queue has room
//   alu_A[7:0], alu_B[7:0], alu_FunSel[3:0]            : registered ALU drive
//   alu_Out[7:0], alu_Flags[3:0] ({Z,C,N,O})           : ALU registered outputs
//   res_valid, res_data[7:0], res_flags[3:0]           : result out
//   res_ready                                          : consumer takes result
//   res_parity                                         : XOR of res_data, only
//                                                        with ALU_ISSUE_PARITY_EN
//
// Modports: slave  = the issue queue's view,
//           master = the environment's view (requester, ALU, consumer).
// Optional feature macro: ALU_ISSUE_PARITY_EN.

interface alu_issue_queue_if;
    logic       req_valid;
    logic [7:0] req_A;
    logic [7:0] req_B;
    logic [3:0] req_FunSel;
    logic       req_ready;
    logic [7:0] alu_A;
    logic [7:0] alu_B;
    logic [3:0] alu_FunSel;
    logic [7:0] alu_Out;
    logic [3:0] alu_Flags;
    logic       res_valid;
    logic [7:0] res_data;
    logic [3:0] res_flags;
    logic       res_ready;
`ifdef ALU_ISSUE_PARITY_EN
    logic       res_parity;

    modport slave (
        input  req_valid, req_A, req_B, req_FunSel, alu_Out, alu_Flags, res_ready,
        output req_ready, alu_A, alu_B, alu_FunSel, res_valid, res_data, res_flags,
               res_parity
    );
    modport master (
        output req_valid, req_A, req_B, req_FunSel, alu_Out, alu_Flags, res_ready,
        input  req_ready, alu_A, alu_B, alu_FunSel, res_valid, res_data, res_flags,
               res_parity
    );
`else
    modport slave (
        input  req_valid, req_A, req_B, req_FunSel, alu_Out, alu_Flags, res_ready,
        output req_ready, alu_A, alu_B, alu_FunSel, res_valid, res_data, res_flags
    );
    modport master (
        output req_valid, req_A, req_B, req_FunSel, alu_Out, alu_Flags, res_ready,
        input  req_ready, alu_A, alu_B, alu_FunSel, res_valid, res_data, res_flags
    );
`endif
endinterface

// File: rtl/alu_issue_queue.sv
// alu_issue_queue -- 4-entry in-order issue queue in front of a registered ALU.
//
// Requests {A,B,FunSel} are pushed into a 4-deep FIFO. A four-state FSM
// (IDLE -> ISSUE -> WAIT -> DONE) takes one entry at a time, presents it to
// the ALU for exactly one clock edge, captures the ALU's registered result
// one edge later and holds it on the result channel until res_ready.
// Outside ISSUE the ALU is driven with A=B=0, FunSel=0000 (pass A) so the
// ALU's carry flag survives between operations (carry-chained shifts).
//
// Ports:
//   clk  : single clock, all state updates on its rising edge
//   rst  : asynchronous active-high reset; clears FSM, FIFO pointers/count
//          and all registered outputs immediately
//   bus  : alu_issue_queue_if.slave (request, ALU and result channels)
//
// Optional feature macro: ALU_ISSUE_PARITY_EN adds res_parity (XOR of
// res_data), captured with res_data and cleared by reset.

module alu_issue_queue (
    input  logic              clk,
    input  logic              rst,
    alu_issue_queue_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_reg;
    logic [2:0]       count_reg;
    logic [1:0]       rd_ptr_reg;
    logic [1:0]       wr_ptr_reg;
    logic [3:0][19:0] entry_flat;
    logic [3:0]       wr_en;
    logic [19:0]      head;
    logic             req_ready;
    logic             push;
    logic             pop;

    logic [7:0]       alu_a_reg;
    logic [7:0]       alu_b_reg;
    logic [3:0]       alu_fs_reg;
    logic             res_valid_reg;
    logic [7:0]       res_data_reg;
    logic [3:0]       res_flags_reg;
`ifdef ALU_ISSUE_PARITY_EN
    logic             res_parity_reg;
`endif

    // Ready looks only at the occupancy, so a full queue never accepts even
    // when the head is being popped in the same cycle.
    assign req_ready = ~count_reg[2];
    assign push      = bus.req_valid & req_ready;
    assign pop       = (state_reg == IDLE) && (count_reg != 3'd0);
    assign head      = entry_flat[rd_ptr_reg];

    // FIFO storage: one register per entry, written only when the write
    // pointer selects it. Contents need no reset; count guards their use.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_entry
            logic [19:0] data_reg;

            assign wr_en[gi]      = push && (wr_ptr_reg == 2'(gi));
            assign entry_flat[gi] = data_reg;

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    data_reg <= {bus.req_A, bus.req_B, bus.req_FunSel};
                end
            end
        end
    endgenerate

    // Pointers wrap naturally at 2 bits; push+pop together leaves count alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg  <= 3'd0;
            rd_ptr_reg <= 2'd0;
            wr_ptr_reg <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Issue FSM with registered ALU drive and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            alu_a_reg      <= 8'h00;
            alu_b_reg      <= 8'h00;
            alu_fs_reg     <= 4'b0000;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= 8'h00;
            res_flags_reg  <= 4'b0000;
`ifdef ALU_ISSUE_PARITY_EN
            res_parity_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        alu_a_reg  <= head[19:12];
                        alu_b_reg  <= head[11:4];
                        alu_fs_reg <= head[3:0];
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // The ALU samples the operation at this edge; drop back
                    // to pass-A of zero so it executes exactly once.
                    alu_a_reg  <= 8'h00;
                    alu_b_reg  <= 8'h00;
                    alu_fs_reg <= 4'b0000;
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    res_data_reg   <= bus.alu_Out;
                    res_flags_reg  <= bus.alu_Flags;
`ifdef ALU_ISSUE_PARITY_EN
                    res_parity_reg <= ^bus.alu_Out;
`endif
                    res_valid_reg  <= 1'b1;
                    state_reg      <= DONE;
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_A      = alu_a_reg;
    assign bus.alu_B      = alu_b_reg;
    assign bus.alu_FunSel = alu_fs_reg;
    assign bus.res_valid  = res_valid_reg;
    assign bus.res_data   = res_data_reg;
    assign bus.res_flags  = res_flags_reg;
`ifdef ALU_ISSUE_PARITY_EN
    assign bus.res_parity = res_parity_reg;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue -- self-checking bench for alu_issue_queue.
// Contains a registered ALU stand-in (never reset, like the real ALU), an
// in-order expectation queue filled at acceptance time, and a monitor that
// pops and compares on every result handshake.

module tb_alu_issue_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    alu_issue_queue_if bus();

    alu_issue_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        logic [3:0] mask;
    } exp_t;

    exp_t       exp_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         n_results = 0;
    logic [3:0] model_flags = 4'b0000;
    bit         rr_random = 1'b0;
    bit         rr_value  = 1'b0;
    logic [3:0] fs_list [7] = '{4'b0000, 4'b0100, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b1111};

    // ALU behaviour: returns {result, {Z,C,N,O}}. Add/sub overflow bit is
    // reported the way the target ALU does it: set when the carry into bit 7
    // equals the carry out. Logic ops, shifts and pass keep C and/or O.
    function automatic logic [11:0] alu_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] f, input logic [3:0] fl_in);
        logic [8:0] sum;
        logic [7:0] low;
        logic [7:0] r;
        logic       c;
        logic       o;
        c = fl_in[2];
        o = fl_in[0];
        r = a;
        case (f)
            4'b0100: begin
                sum = {1'b0, a} + {1'b0, b};
                low = {1'b0, a[6:0]} + {1'b0, b[6:0]};
                r = sum[7:0]; c = sum[8]; o = ~(low[7] ^ sum[8]);
            end
            4'b0101: begin
                sum = {1'b0, a} + {1'b0, ~b} + 9'd1;
                low = {1'b0, a[6:0]} + {1'b0, ~b[6:0]} + 8'd1;
                r = sum[7:0]; c = sum[8]; o = ~(low[7] ^ sum[8]);
            end
            4'b0111: r = a & b;
            4'b1001: r = a ^ b;
            4'b1011: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'b1111: begin r = {c, a[7:1]};    c = a[0]; end
            default: r = a;
        endcase
        return {r, (r == 8'h00), c, r[7], o};
    endfunction

    // ALU stand-in: registered outputs, flags persist across our resets.
    logic [7:0] alu_out_q   = 8'h00;
    logic [3:0] alu_flags_q = 4'b0000;
    always @(posedge clk) begin
        {alu_out_q, alu_flags_q} <= alu_op(bus.alu_A, bus.alu_B, bus.alu_FunSel, alu_flags_q);
    end
    assign bus.alu_Out   = alu_out_q;
    assign bus.alu_Flags = alu_flags_q;

    task automatic check(input bit ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the accepted op stream executed in order on a carry state.
    task automatic model_accept(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                                input bit use_const, input logic [7:0] cdata,
                                input logic [3:0] cflags, input logic [3:0] cmask);
        logic [11:0] r;
        exp_t        e;
        r = alu_op(a, b, f, model_flags);
        model_flags = r[3:0];
        if (use_const) e = '{cdata, cflags, cmask};
        else           e = '{r[11:4], r[3:0], 4'hF};
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                        input bit use_const, input logic [7:0] cdata,
                        input logic [3:0] cflags, input logic [3:0] cmask);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1; bus.req_A = a; bus.req_B = b; bus.req_FunSel = f;
        for (int i = 0; i < 200; i++) begin
            ok = (bus.req_ready === 1'b1);
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        if (ok) model_accept(a, b, f, use_const, cdata, cflags, cmask);
        else    check(1'b0, "send_timeout", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 1000 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (bus.res_valid === 1'b0);
        end
        check(done, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rr_driver();
        forever begin
            @(posedge clk);
            #2;
            bus.res_ready = rr_random ? ($urandom_range(0, 2) != 0) : rr_value;
        end
    endtask

    task automatic monitor();
        bit         hold_pending;
        bit         prev_fs;
        logic [7:0] hold_data;
        logic [3:0] hold_flags;
        exp_t       e;
        hold_pending = 1'b0; prev_fs = 1'b0; hold_data = 8'h00; hold_flags = 4'h0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                hold_pending = 1'b0;
                prev_fs      = 1'b0;
            end else begin
                if (hold_pending)
                    check(bus.res_valid === 1'b1 && bus.res_data === hold_data &&
                          bus.res_flags === hold_flags, "res_hold",
                          {19'd0, bus.res_valid, bus.res_data, bus.res_flags},
                          {19'd0, 1'b1, hold_data, hold_flags});
                hold_pending = 1'b0;
                if (bus.alu_FunSel !== 4'b0000) begin
                    check(!prev_fs, "funsel_one_edge", 32'(bus.alu_FunSel), 32'd0);
                    prev_fs = 1'b1;
                end else begin
                    prev_fs = 1'b0;
                end
                if (bus.res_valid === 1'b1) begin
                    if (bus.res_ready === 1'b1) begin
                        n_results++;
                        $display("[TB] result %0d: data=0x%02h flags=%04b", n_results,
                                 bus.res_data, bus.res_flags);
                        if (exp_q.size() == 0) begin
                            check(1'b0, "unexpected_result", 32'(bus.res_data), 32'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check(bus.res_data === e.data, "res_data",
                                  32'(bus.res_data), 32'(e.data));
                            check((bus.res_flags & e.mask) === (e.flags & e.mask), "res_flags",
                                  32'(bus.res_flags & e.mask), 32'(e.flags & e.mask));
`ifdef ALU_ISSUE_PARITY_EN
                            check(bus.res_parity === ^e.data, "res_parity",
                                  32'(bus.res_parity), 32'(^e.data));
`endif
                        end
                    end else begin
                        hold_pending = 1'b1;
                        hold_data    = bus.res_data;
                        hold_flags   = bus.res_flags;
                    end
                end
            end
        end
    endtask

    task automatic stimulus();
        logic [3:0] v;
        logic [3:0] saved_flags;
        int         acc;
        int         idx;
        int         base;
        int         seen;
        bit         ok;
        logic [7:0] bp_a [6];
        logic [7:0] bp_b [6];
        logic [3:0] bp_f [6];

        bus.req_valid = 1'b0; bus.req_A = 8'h00; bus.req_B = 8'h00;
        bus.req_FunSel = 4'h0; bus.res_ready = 1'b0;

        // Asynchronous reset: checked before any clock edge has occurred.
        #1 rst = 1'b1;
        #1;
        check(bus.res_valid === 1'b0,     "rst_res_valid",  32'(bus.res_valid),  32'd0);
        check(bus.res_data === 8'h00,     "rst_res_data",   32'(bus.res_data),   32'd0);
        check(bus.res_flags === 4'h0,     "rst_res_flags",  32'(bus.res_flags),  32'd0);
        check(bus.alu_A === 8'h00,        "rst_alu_A",      32'(bus.alu_A),      32'd0);
        check(bus.alu_B === 8'h00,        "rst_alu_B",      32'(bus.alu_B),      32'd0);
        check(bus.alu_FunSel === 4'h0,    "rst_alu_FunSel", 32'(bus.alu_FunSel), 32'd0);
        check(bus.req_ready === 1'b1,     "rst_req_ready",  32'(bus.req_ready),  32'd1);
`ifdef ALU_ISSUE_PARITY_EN
        check(bus.res_parity === 1'b0,    "rst_res_parity", 32'(bus.res_parity), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rr_value = 1'b1;
        repeat (2) @(negedge clk);

        // Add 0x7F+0x01 with latency profile: valid only after the 3rd edge.
        send(8'h7F, 8'h01, 4'b0100, 1'b1, 8'h80, 4'b0010, 4'hF);
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            v[k] = bus.res_valid;
        end
        check(v === 4'b0010, "latency_pulse", 32'(v), 32'b0010);
        wait_idle();

        // Carry-out add, small add (parity 0), carry-chained shifts.
        send(8'hFF, 8'h01, 4'b0100, 1'b1, 8'h00, 4'b1101, 4'hF);
        send(8'h01, 8'h02, 4'b0100, 1'b1, 8'h03, 4'b0000, 4'h0);
        send(8'h81, 8'h00, 4'b1011, 1'b1, 8'h02, 4'b0100, 4'b0100);
        send(8'h04, 8'h00, 4'b1111, 1'b1, 8'h82, 4'b0000, 4'b0100);
        wait_idle();

        // Backpressure: 6 offered, 5 accepted, ready stays low.
        rr_value = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            bp_a[k] = 8'($urandom); bp_b[k] = 8'($urandom);
            bp_f[k] = fs_list[$urandom_range(0, 6)];
        end
        acc = 0; idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            bus.req_valid = 1'b1;
            bus.req_A = bp_a[idx]; bus.req_B = bp_b[idx]; bus.req_FunSel = bp_f[idx];
            ok = (bus.req_ready === 1'b1);
            @(posedge clk);
            if (ok) begin
                model_accept(bp_a[idx], bp_b[idx], bp_f[idx], 1'b0, 8'h00, 4'h0, 4'h0);
                acc++;
                if (idx < 5) idx++;
            end
            @(negedge clk);
        end
        check(acc == 5, "bp_accepted", 32'(acc), 32'd5);
        check(bus.req_ready === 1'b0, "bp_ready_low", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        base = n_results;
        rr_value = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.req_ready === 1'b1);
        end
        check(ok && (n_results == base + 1), "bp_ready_after_first_pop",
              32'(n_results - base), 32'd1);
        wait_idle();

        // Reset while the first op sits in WAIT with a second one queued.
        saved_flags = 4'h0;
        send(8'($urandom), 8'($urandom), 4'b0100, 1'b0, 8'h00, 4'h0, 4'h0);
        saved_flags = model_flags;
        send(8'($urandom), 8'($urandom), 4'b0101, 1'b0, 8'h00, 4'h0, 4'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check(bus.res_valid === 1'b0,  "midwait_res_valid",  32'(bus.res_valid),  32'd0);
        check(bus.alu_FunSel === 4'h0, "midwait_alu_FunSel", 32'(bus.alu_FunSel), 32'd0);
        check(bus.req_ready === 1'b1,  "midwait_req_ready",  32'(bus.req_ready),  32'd1);
        exp_q.delete();
        model_flags = saved_flags;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) seen++;
        end
        check(seen == 0, "midwait_no_result", 32'(seen), 32'd0);

        // Randomized traffic with random result backpressure.
        rr_random = 1'b1;
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(8'($urandom), 8'($urandom), fs_list[$urandom_range(0, 6)],
                 1'b0, 8'h00, 4'h0, 4'h0);
        end
        rr_random = 1'b0;
        rr_value  = 1'b1;
        wait_idle();
    endtask

    initial begin
        fork
            monitor();
            rr_driver();
            stimulus();
        join_any
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
